// File: rtl/ewrapper_link_tx_framer.sv
// ewrapper_link_tx_framer
// Packs one emesh transaction per accept into the 64-bit, eight-lane word
// stream feeding the LVDS serializer. Lane0 is txo_data[63:56] and goes out
// first; txo_frame[7] flags lane0.
//
// A standalone packet takes two cycles (HDR then TAIL). With the optional
// macro TXO_BURST_EN defined, contiguous double-word writes that follow a
// header collapse into one-cycle BURST beats. Without the macro, burst_en and
// BURST_MAX are ignored and every transaction is sent as HDR + TAIL.
//
// State | meaning
// IDLE  | nothing on the link, ready to accept
// HDR   | header word out (ctrl byte, dstaddr, data[31:8]); upstream stalled
// TAIL  | tail word out (data[7:0], srcaddr, pad); may accept the next one
// BURST | burst beat out (data, srcaddr); only with TXO_BURST_EN
module ewrapper_link_tx_framer #(
    parameter int          BURST_MAX = 16,
    parameter logic [7:0]  PAD_BYTE  = 8'h00
) (
    input  logic        txo_lclk,
    input  logic        reset_n,
    input  logic        txo_emesh_access,
    input  logic        txo_emesh_write,
    input  logic [1:0]  txo_emesh_datamode,
    input  logic [3:0]  txo_emesh_ctrlmode,
    input  logic [31:0] txo_emesh_dstaddr,
    input  logic [31:0] txo_emesh_srcaddr,
    input  logic [31:0] txo_emesh_data,
    input  logic        burst_en,
    output logic        txo_emesh_wait,
    output logic [63:0] txo_data,
    output logic [7:0]  txo_frame
);

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        TAIL
`ifdef TXO_BURST_EN
        ,
        BURST
`endif
    } state_t;

    localparam logic [63:0] PAD_WORD    = {8{PAD_BYTE}};
    localparam logic [7:0]  BURST_MAX_B = 8'(BURST_MAX);

    state_t      state;
    logic [7:0]  hold_data_lo;
    logic [31:0] hold_src;

    logic        accept;
    logic [7:0]  ctrl_byte;
    logic [63:0] hdr_word;
    logic [63:0] tail_word;

    // Busy only while the header goes out; the tail cycle can already accept.
    assign txo_emesh_wait = (state == HDR);
    assign accept         = txo_emesh_access & ~txo_emesh_wait;
    assign ctrl_byte      = {txo_emesh_ctrlmode, txo_emesh_datamode, txo_emesh_write, 1'b1};
    assign hdr_word       = {ctrl_byte, txo_emesh_dstaddr, txo_emesh_data[31:8]};
    assign tail_word      = {hold_data_lo, hold_src, {3{PAD_BYTE}}};

`ifdef TXO_BURST_EN
    logic        hist_valid;
    logic [3:0]  hist_ctrl;
    logic [31:0] hist_dst;
    logic [7:0]  beat_cnt;
    logic        dbl_write;
    logic [32:0] next_dst;
    logic        eligible;

    // A beat must continue an unbroken run of double writes at the next
    // 8-byte address; the 33-bit sum rejects the wrap from 0xFFFFFFF8.
    assign dbl_write = txo_emesh_write & (txo_emesh_datamode == 2'b11);
    assign next_dst  = {1'b0, hist_dst} + 33'd8;
    assign eligible  = burst_en & dbl_write & hist_valid
                     & (txo_emesh_ctrlmode == hist_ctrl)
                     & ({1'b0, txo_emesh_dstaddr} == next_dst)
                     & (beat_cnt < BURST_MAX_B);
`else
    logic unused_cfg;
    assign unused_cfg = burst_en ^ BURST_MAX_B[0];
`endif

    // Framing state machine with registered lane/frame outputs.
    always_ff @(posedge txo_lclk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            txo_data     <= PAD_WORD;
            txo_frame    <= 8'h00;
            hold_data_lo <= 8'h00;
            hold_src     <= 32'h0;
`ifdef TXO_BURST_EN
            hist_valid   <= 1'b0;
            hist_ctrl    <= 4'h0;
            hist_dst     <= 32'h0;
            beat_cnt     <= 8'h00;
`endif
        end else begin
            if (accept) begin
                hold_data_lo <= txo_emesh_data[7:0];
                hold_src     <= txo_emesh_srcaddr;
`ifdef TXO_BURST_EN
                hist_valid   <= dbl_write;
                hist_ctrl    <= txo_emesh_ctrlmode;
                hist_dst     <= txo_emesh_dstaddr;
`endif
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= HDR;
                        txo_data  <= hdr_word;
                        txo_frame <= 8'hFF;
`ifdef TXO_BURST_EN
                        beat_cnt  <= 8'h00;
`endif
                    end else begin
                        txo_data  <= PAD_WORD;
                        txo_frame <= 8'h00;
                    end
                end
                HDR: begin
                    state     <= TAIL;
                    txo_data  <= tail_word;
                    txo_frame <= 8'hF8;
                end
                default: begin
                    if (accept) begin
`ifdef TXO_BURST_EN
                        if (eligible) begin
                            state     <= BURST;
                            txo_data  <= {txo_emesh_data, txo_emesh_srcaddr};
                            txo_frame <= 8'hFF;
                            beat_cnt  <= beat_cnt + 8'd1;
                        end else begin
                            state     <= HDR;
                            txo_data  <= hdr_word;
                            txo_frame <= 8'hFF;
                            beat_cnt  <= 8'h00;
                        end
`else
                        state     <= HDR;
                        txo_data  <= hdr_word;
                        txo_frame <= 8'hFF;
`endif
                    end else begin
                        // An idle cycle ends any burst in progress.
                        state     <= IDLE;
                        txo_data  <= PAD_WORD;
                        txo_frame <= 8'h00;
`ifdef TXO_BURST_EN
                        hist_valid <= 1'b0;
                        beat_cnt   <= 8'h00;
`endif
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ewrapper_link_tx_framer.sv
// Directed testbench for ewrapper_link_tx_framer. Instance a uses the default
// BURST_MAX, instance b uses BURST_MAX=2; both share the same stimulus.
module tb_ewrapper_link_tx_framer;

    localparam int K_I = 0;
    localparam int K_H = 1;
    localparam int K_T = 2;
    localparam int K_B = 3;

    typedef struct packed {
        logic        wr;
        logic [1:0]  dm;
        logic [3:0]  cm;
        logic [31:0] dst;
        logic [31:0] src;
        logic [31:0] data;
    } tx_t;

    typedef struct {
        bit pres;
        int kind;
        int idx;
    } step_t;

    logic        txo_lclk = 1'b0;
    logic        reset_n;
    logic        access;
    logic        write;
    logic [1:0]  datamode;
    logic [3:0]  ctrlmode;
    logic [31:0] dstaddr;
    logic [31:0] srcaddr;
    logic [31:0] data;
    logic        burst_en;

    logic        a_wait, b_wait;
    logic [63:0] a_data, b_data;
    logic [7:0]  a_frame, b_frame;

    int n_cmp = 0;
    int n_bad = 0;

    tx_t   txs[$];
    step_t steps[$];

    ewrapper_link_tx_framer u_a (
        .txo_lclk(txo_lclk), .reset_n(reset_n),
        .txo_emesh_access(access), .txo_emesh_write(write),
        .txo_emesh_datamode(datamode), .txo_emesh_ctrlmode(ctrlmode),
        .txo_emesh_dstaddr(dstaddr), .txo_emesh_srcaddr(srcaddr),
        .txo_emesh_data(data), .burst_en(burst_en),
        .txo_emesh_wait(a_wait), .txo_data(a_data), .txo_frame(a_frame)
    );

    ewrapper_link_tx_framer #(.BURST_MAX(2)) u_b (
        .txo_lclk(txo_lclk), .reset_n(reset_n),
        .txo_emesh_access(access), .txo_emesh_write(write),
        .txo_emesh_datamode(datamode), .txo_emesh_ctrlmode(ctrlmode),
        .txo_emesh_dstaddr(dstaddr), .txo_emesh_srcaddr(srcaddr),
        .txo_emesh_data(data), .burst_en(burst_en),
        .txo_emesh_wait(b_wait), .txo_data(b_data), .txo_frame(b_frame)
    );

    always #5 txo_lclk = ~txo_lclk;

    function automatic tx_t mk(logic wr, logic [1:0] dm, logic [3:0] cm, logic [31:0] dst);
        tx_t t;
        t.wr   = wr;
        t.dm   = dm;
        t.cm   = cm;
        t.dst  = dst;
        t.data = dst ^ 32'h5A5A_0F0F;
        t.src  = ~dst + 32'h0000_1357;
        return t;
    endfunction

    function automatic logic [63:0] exp_word(int kind, tx_t t);
        case (kind)
            K_H:     return {t.cm, t.dm, t.wr, 1'b1, t.dst, t.data[31:8]};
            K_T:     return {t.data[7:0], t.src, 24'h000000};
            K_B:     return {t.data, t.src};
            default: return 64'h0;
        endcase
    endfunction

    function automatic logic [7:0] exp_frame(int kind);
        case (kind)
            K_H, K_B: return 8'hFF;
            K_T:      return 8'hF8;
            default:  return 8'h00;
        endcase
    endfunction

    task automatic chk(string tag, logic [7:0] f, logic w, logic [63:0] d,
                       logic [7:0] ef, logic ew, logic [63:0] ed);
        n_cmp++;
        assert (f === ef) else begin
            n_bad++;
            $error("FAIL %s frame got %h want %h", tag, f, ef);
        end
        n_cmp++;
        assert (w === ew) else begin
            n_bad++;
            $error("FAIL %s wait got %b want %b", tag, w, ew);
        end
        n_cmp++;
        assert (d === ed) else begin
            n_bad++;
            $error("FAIL %s data got %h want %h", tag, d, ed);
        end
    endtask

    task automatic present(tx_t t);
        access   = 1'b1;
        write    = t.wr;
        datamode = t.dm;
        ctrlmode = t.cm;
        dstaddr  = t.dst;
        srcaddr  = t.src;
        data     = t.data;
    endtask

    task automatic tick();
        @(posedge txo_lclk);
        #1;
    endtask

    task automatic add(bit p, int k, int i);
        step_t s;
        s.pres = p;
        s.kind = k;
        s.idx  = i;
        steps.push_back(s);
    endtask

    // Replays the step table: present the next pending transaction when the
    // step says so, advance it on expected HDR/BURST accepts, check outputs.
    // inst: 0 = instance a, 1 = instance b, 2 = both.
    task automatic run(string tag, int inst);
        int  nxt = 0;
        tx_t t;
        for (int s = 0; s < steps.size(); s++) begin
            if (steps[s].pres && nxt < txs.size()) present(txs[nxt]);
            else access = 1'b0;
            tick();
            if (steps[s].kind == K_H || steps[s].kind == K_B) nxt++;
            t = txs[steps[s].idx];
            if (inst != 1)
                chk($sformatf("%s_a[%0d]", tag, s), a_frame, a_wait, a_data,
                    exp_frame(steps[s].kind), steps[s].kind == K_H,
                    exp_word(steps[s].kind, t));
            if (inst != 0)
                chk($sformatf("%s_b[%0d]", tag, s), b_frame, b_wait, b_data,
                    exp_frame(steps[s].kind), steps[s].kind == K_H,
                    exp_word(steps[s].kind, t));
        end
        access = 1'b0;
        steps.delete();
        txs.delete();
        repeat (3) tick();
    endtask

    initial begin
        tx_t t;
        reset_n  = 1'b0;
        access   = 1'b0;
        write    = 1'b0;
        datamode = 2'b00;
        ctrlmode = 4'h0;
        dstaddr  = 32'h0;
        srcaddr  = 32'h0;
        data     = 32'h0;
        burst_en = 1'b1;
        #12;
        chk("rst_a", a_frame, a_wait, a_data, 8'h00, 1'b0, 64'h0);
        chk("rst_b", b_frame, b_wait, b_data, 8'h00, 1'b0, 64'h0);
        reset_n = 1'b1;
        tick();

        // Single write, hand-computed words.
        t.wr = 1'b1; t.dm = 2'b10; t.cm = 4'h0;
        t.dst = 32'h8080_0000; t.data = 32'h1122_3344; t.src = 32'h5566_7788;
        present(t);
        tick();
        access = 1'b0;
        chk("single_c1", a_frame, a_wait, a_data, 8'hFF, 1'b1, 64'h0B80_8000_0011_2233);
        tick();
        chk("single_c2", a_frame, a_wait, a_data, 8'hF8, 1'b0, 64'h4455_6677_8800_0000);
        tick();
        chk("single_c3", a_frame, a_wait, a_data, 8'h00, 1'b0, 64'h0);

        // Asynchronous reset while the header is on the link.
        present(t);
        tick();
        access = 1'b0;
        chk("pre_rst", a_frame, a_wait, a_data, 8'hFF, 1'b1, 64'h0B80_8000_0011_2233);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst", a_frame, a_wait, a_data, 8'h00, 1'b0, 64'h0);
        #2 reset_n = 1'b1;
        tick();
        chk("post_rst", a_frame, a_wait, a_data, 8'h00, 1'b0, 64'h0);

        // Three contiguous double writes.
        txs.push_back(mk(1'b1, 2'b11, 4'h0, 32'h100));
        txs.push_back(mk(1'b1, 2'b11, 4'h0, 32'h108));
        txs.push_back(mk(1'b1, 2'b11, 4'h0, 32'h110));
`ifdef TXO_BURST_EN
        add(1, K_H, 0); add(1, K_T, 0); add(1, K_B, 1); add(1, K_B, 2); add(0, K_I, 0);
`else
        add(1, K_H, 0); add(1, K_T, 0); add(1, K_H, 1); add(1, K_T, 1);
        add(1, K_H, 2); add(1, K_T, 2); add(0, K_I, 0);
`endif
        run("burst", 2);

        // Idle cycle between 0x108 and 0x110.
        txs.push_back(mk(1'b1, 2'b11, 4'h0, 32'h100));
        txs.push_back(mk(1'b1, 2'b11, 4'h0, 32'h108));
        txs.push_back(mk(1'b1, 2'b11, 4'h0, 32'h110));
`ifdef TXO_BURST_EN
        add(1, K_H, 0); add(1, K_T, 0); add(1, K_B, 1); add(0, K_I, 0);
        add(1, K_H, 2); add(1, K_T, 2); add(0, K_I, 0);
`else
        add(1, K_H, 0); add(1, K_T, 0); add(1, K_H, 1); add(1, K_T, 1); add(0, K_I, 0);
        add(1, K_H, 2); add(1, K_T, 2); add(0, K_I, 0);
`endif
        run("idle_brk", 2);

        // burst_en low: every transaction gets its own header.
        burst_en = 1'b0;
        txs.push_back(mk(1'b1, 2'b11, 4'h0, 32'h100));
        txs.push_back(mk(1'b1, 2'b11, 4'h0, 32'h108));
        txs.push_back(mk(1'b1, 2'b11, 4'h0, 32'h110));
        add(1, K_H, 0); add(1, K_T, 0); add(1, K_H, 1); add(1, K_T, 1);
        add(1, K_H, 2); add(1, K_T, 2); add(0, K_I, 0);
        run("ben_off", 2);
        burst_en = 1'b1;

        // Ctrlmode change.
        txs.push_back(mk(1'b1, 2'b11, 4'h0, 32'h100));
        txs.push_back(mk(1'b1, 2'b11, 4'h5, 32'h108));
        add(1, K_H, 0); add(1, K_T, 0); add(1, K_H, 1); add(1, K_T, 1); add(0, K_I, 0);
        run("ctrl_brk", 2);

        // Read interleaved between contiguous writes.
        txs.push_back(mk(1'b1, 2'b11, 4'h0, 32'h100));
        txs.push_back(mk(1'b0, 2'b11, 4'h0, 32'h108));
        txs.push_back(mk(1'b1, 2'b11, 4'h0, 32'h110));
        add(1, K_H, 0); add(1, K_T, 0); add(1, K_H, 1); add(1, K_T, 1);
        add(1, K_H, 2); add(1, K_T, 2); add(0, K_I, 0);
        run("read_brk", 2);

        // Address wrap is never contiguous.
        txs.push_back(mk(1'b1, 2'b11, 4'h0, 32'hFFFF_FFF8));
        txs.push_back(mk(1'b1, 2'b11, 4'h0, 32'h0000_0000));
        add(1, K_H, 0); add(1, K_T, 0); add(1, K_H, 1); add(1, K_T, 1); add(0, K_I, 0);
        run("wrap_brk", 2);

        // Five contiguous writes, BURST_MAX=2 instance.
        for (int i = 0; i < 5; i++) txs.push_back(mk(1'b1, 2'b11, 4'h3, 32'h200 + 32'(8 * i)));
`ifdef TXO_BURST_EN
        add(1, K_H, 0); add(1, K_T, 0); add(1, K_B, 1); add(1, K_B, 2);
        add(1, K_H, 3); add(1, K_T, 3); add(1, K_B, 4); add(0, K_I, 0);
`else
        for (int i = 0; i < 5; i++) begin
            add(1, K_H, i); add(1, K_T, i);
        end
        add(0, K_I, 0);
`endif
        run("bmax2", 1);

        // Same five writes, default BURST_MAX instance.
        for (int i = 0; i < 5; i++) txs.push_back(mk(1'b1, 2'b11, 4'h3, 32'h200 + 32'(8 * i)));
`ifdef TXO_BURST_EN
        add(1, K_H, 0); add(1, K_T, 0); add(1, K_B, 1); add(1, K_B, 2);
        add(1, K_B, 3); add(1, K_B, 4); add(0, K_I, 0);
`else
        for (int i = 0; i < 5; i++) begin
            add(1, K_H, i); add(1, K_T, i);
        end
        add(0, K_I, 0);
`endif
        run("bmax16", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ewrapper_link_tx_framer.md
Name: ewrapper_link_tx_framer

Overview:
- Packs one emesh transaction per accept into the 8-byte-per-cycle parallel word stream for the LVDS serializer.
- Sits directly downstream of the transmitter's FIFO read/arbitration stage, clocked by the transmitter lclk.
- Two cycles per standalone packet.
- Contiguous double-word writes collapse into one-cycle burst beats.
- Back-pressures the arbitration stage through txo_emesh_wait.

Parameters:
- BURST_MAX, 16, max burst beats after a header packet before a new header is forced (1..255).
- PAD_BYTE, 8'h00, value driven on unused/idle byte lanes.

Ports:
- txo_lclk  input  1  transmitter clock, all logic rising-edge.
- reset_n  input  1  asynchronous active-low reset.
- txo_emesh_access  input  1  transaction valid.
- txo_emesh_write  input  1  1=write, 0=read.
- txo_emesh_datamode  input  2  access size, 2'b11 = double.
- txo_emesh_ctrlmode  input  4  control mode.
- txo_emesh_dstaddr  input  32  destination address.
- txo_emesh_srcaddr  input  32  source address / upper data word.
- txo_emesh_data  input  32  data / lower data word.
- burst_en  input  1  burst enable control.
- txo_emesh_wait  output  1  registered busy; a transaction is accepted only when access=1 and wait=0.
- txo_data  output  64  eight byte lanes; lane0 = [63:56] is sent first.
- txo_frame  output  8  per-lane frame; bit7 = lane0.

Behaviour:
- Reset (async, reset_n=0):
  - txo_data = {8{PAD_BYTE}}, txo_frame = 0, txo_emesh_wait = 0.
  - State IDLE, beat count 0, burst history invalid.
  - A partial packet in flight is dropped. First accept is possible at the first edge after deassertion.
- Ctrl byte CB = {ctrlmode[3:0], datamode[1:0], write, 1'b1}.
- States: IDLE, HDR, TAIL, BURST. All outputs are registered.
- Accept at edge N (access & ~wait):
  - Non-burst: edge N → HDR. Outputs: lanes {CB, dst[31:24], dst[23:16], dst[15:8], dst[7:0], data[31:24], data[23:16], data[15:8]}, frame 8'hFF, wait=1.
  - Edge N+1 → TAIL. Outputs: lanes {data[7:0], src[31:24], src[23:16], src[15:8], src[7:0], PAD, PAD, PAD}, frame 8'hF8, wait=0.
  - Latency is 1 cycle from accept to first word. Back-to-back standalone packets give a sustained rate of 1 packet per 2 cycles.
- Burst eligibility of a transaction accepted at an edge where state is TAIL or BURST requires all of:
  - burst_en=1, write=1, datamode=2'b11;
  - previous accepted transaction was a double write;
  - ctrlmode equal to the previous one;
  - dstaddr == prev_dstaddr + 8 with no 32-bit carry out (0xFFFFFFF8 → 0x00000000 is never eligible);
  - beat count < BURST_MAX.
- Reads never burst.
- Eligible accept → BURST. Outputs: lanes {data[31:24..7:0], src[31:24..7:0]}, frame 8'hFF, wait=0, beat count +1.
- Ineligible accept in TAIL/BURST → HDR (new header), beat count cleared.
- No accept in TAIL/BURST/HDR-exit → IDLE: frame 0, data PAD, wait=0, burst history invalidated (an idle cycle breaks a burst).
- beat count == BURST_MAX → next contiguous write is sent as HDR+TAIL, and count restarts at 0.
- txo_emesh_wait is a pure function of the state register (1 only in HDR). No combinational path from inputs to outputs.
- Inputs presented while wait=1 are ignored; the upstream stage holds them.

Optional Feature:
- Macro TXO_BURST_EN.
- Defined: burst logic as above.
- Undefined: burst_en ignored, BURST state absent, every transaction is HDR+TAIL, no history/counter registers.

Test Plan:
- Reset mid-packet: assert reset_n=0 while in HDR → txo_frame=0, data=0x0000000000000000, wait=0 immediately (async).
- Single write: dst=0x80800000, data=0x11223344, src=0x55667788, ctrl=0, dm=2'b10.
  - Cycle 1 → data=0x0B80800000112233, frame=0xFF, wait=1.
  - Cycle 2 → data=0x4455667788000000, frame=0xF8, wait=0.
  - Cycle 3 → frame=0x00.
- Burst (macro on, burst_en=1): writes dm=11 to 0x100, 0x108, 0x110 on consecutive accepts → HDR, TAIL, then 2 BURST beats with frame 0xFF each; 4 cycles total, wait=1 only in cycle 1.
- Burst breakers → each forces a new HDR+TAIL:
  - idle cycle between 0x108 and 0x110;
  - ctrlmode change;
  - read interleave;
  - dst 0xFFFFFFF8 → 0x00000000.
- BURST_MAX=2 with 5 contiguous double writes → pattern HDR, TAIL, BURST, BURST, HDR, TAIL, BURST.
- Macro off: same stimulus as the burst test → 3× (HDR, TAIL), 6 cycles, frames FF, F8 repeating.
